// File: rtl/flit_rx_pkg.sv
// Shared flit definitions: type encodings, error causes, FSM states and stat helpers
// for the flit mux / router / receiver blocks.
package flit_rx_pkg;

  localparam int unsigned TYPE_W = 2;
  localparam int unsigned LEN_W  = 16;
  localparam int unsigned DST_W  = 32;
  localparam int unsigned STAT_W = 32;

  typedef enum logic [TYPE_W-1:0] {
    FT_NONE = 2'b00,
    FT_HEAD = 2'b01,
    FT_TAIL = 2'b10,
    FT_DATA = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_ORPHAN = 3'd1,
    ERR_TRUNC  = 3'd2,
    ERR_NULL   = 3'd3,
    ERR_VCH    = 3'd4,
    ERR_MAXLEN = 3'd5
  } err_code_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } state_e;

  // Per-packet capture taken from the head flit.
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic [DST_W-1:0] dst;
  } pkt_info_t;

  function automatic logic [STAT_W-1:0] sat_add(input logic [STAT_W-1:0] a,
                                                input logic [STAT_W-1:0] b);
    logic [STAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[STAT_W] ? '1 : s[STAT_W-1:0];
  endfunction

endpackage

// File: rtl/flit_rx_if.sv
// Incoming flit bus: one flit per cycle, no backpressure.
interface flit_rx_if #(
  parameter int unsigned DATAW_P1 = 66,
  parameter int unsigned VCHW_P1  = 1
);
  logic [DATAW_P1-1:0] idata;
  logic                ivalid;
  logic [VCHW_P1-1:0]  ivch;

  modport master (output idata, ivalid, ivch);
  modport slave  (input  idata, ivalid, ivch);
endinterface

// File: rtl/flit_rx_popcount.sv
// Combinational population count of a WIDTH-bit vector.
module popcount #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] cnt_o_c
);

  always_comb begin
    cnt_o_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_o_c = cnt_o_c + CNT_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/flit_rx.sv
// Flit receiver: reassembles head/data/tail packets, flags protocol errors and
// keeps saturating packet and payload-toggle statistics.
module flit_rx
  import flit_rx_pkg::*;
#(
  parameter int unsigned DATAW_P1 = 66,
  parameter int unsigned VCHW_P1  = 1,
  parameter int unsigned MAXLEN   = 64
) (
  input  logic              clk,
  input  logic              rst,
  flit_rx_if.slave          in_if,
  input  logic              clr,
  output logic              pkt_done,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [DST_W-1:0]  pkt_dst,
  output logic              err,
  output logic [2:0]        err_code,
  output logic [STAT_W-1:0] pkt_cnt,
  output logic [STAT_W-1:0] tgl_cnt
);

  localparam int unsigned PAYW  = DATAW_P1 - TYPE_W;
  localparam int unsigned POP_W = $clog2(PAYW + 1);
  // A DATA flit is legal only while a tail still fits within MAXLEN.
  localparam logic [LEN_W-1:0] LEN_LIMIT = LEN_W'(MAXLEN - 1);

  state_e             state_q, state_d;
  pkt_info_t          cap_q, cap_d;
  logic [VCHW_P1-1:0] vch_q, vch_d;
  logic               pkt_done_q, pkt_done_d;
  logic [LEN_W-1:0]   pkt_len_q, pkt_len_d;
  logic [DST_W-1:0]   pkt_dst_q, pkt_dst_d;
  logic               err_q, err_d;
  err_code_e          err_code_q, err_code_d;
  logic [STAT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
  logic [STAT_W-1:0]  tgl_cnt_q, tgl_cnt_d;
  logic [PAYW-1:0]    prev_q, prev_d;

  flit_type_e         ftype;
  logic [PAYW-1:0]    payload;
  logic [POP_W-1:0]   pop_c;

  assign ftype   = flit_type_e'(in_if.idata[DATAW_P1-1 -: TYPE_W]);
  assign payload = in_if.idata[PAYW-1:0];

  popcount #(
    .WIDTH (PAYW),
    .CNT_W (POP_W)
  ) u_popcount (
    .data_i  (payload ^ prev_q),
    .cnt_o_c (pop_c)
  );

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    vch_d      = vch_q;
    pkt_done_d = 1'b0;
    pkt_len_d  = pkt_len_q;
    pkt_dst_d  = pkt_dst_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    pkt_cnt_d  = pkt_cnt_q;
    tgl_cnt_d  = tgl_cnt_q;
    prev_d     = prev_q;

    if (in_if.ivalid) begin
      prev_d    = payload;
      tgl_cnt_d = sat_add(tgl_cnt_q, STAT_W'(pop_c));

      if (ftype == FT_NONE) begin
        err_d      = 1'b1;
        err_code_d = ERR_NULL;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ftype == FT_HEAD) begin
              state_d   = ST_BODY;
              vch_d     = in_if.ivch;
              cap_d.dst = payload[DST_W-1:0];
              cap_d.len = LEN_W'(1);
            end else begin
              err_d      = 1'b1;
              err_code_d = ERR_ORPHAN;
            end
          end
          ST_BODY: begin
            if (ftype == FT_HEAD) begin
              // Truncated packet: drop it and restart on the new head.
              err_d      = 1'b1;
              err_code_d = ERR_TRUNC;
              vch_d      = in_if.ivch;
              cap_d.dst  = payload[DST_W-1:0];
              cap_d.len  = LEN_W'(1);
            end else if (in_if.ivch != vch_q) begin
              err_d      = 1'b1;
              err_code_d = ERR_VCH;
              state_d    = ST_IDLE;
            end else if (ftype == FT_TAIL) begin
              state_d    = ST_IDLE;
              pkt_done_d = 1'b1;
              pkt_len_d  = cap_q.len + LEN_W'(1);
              pkt_dst_d  = cap_q.dst;
              pkt_cnt_d  = sat_add(pkt_cnt_q, STAT_W'(1));
            end else if (cap_q.len >= LEN_LIMIT) begin
              err_d      = 1'b1;
              err_code_d = ERR_MAXLEN;
              state_d    = ST_IDLE;
            end else begin
              cap_d.len = cap_q.len + LEN_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    if (clr) begin
      pkt_cnt_d = '0;
      tgl_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cap_q      <= '0;
      vch_q      <= '0;
      pkt_done_q <= 1'b0;
      pkt_len_q  <= '0;
      pkt_dst_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      pkt_cnt_q  <= '0;
      tgl_cnt_q  <= '0;
      prev_q     <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      vch_q      <= vch_d;
      pkt_done_q <= pkt_done_d;
      pkt_len_q  <= pkt_len_d;
      pkt_dst_q  <= pkt_dst_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      pkt_cnt_q  <= pkt_cnt_d;
      tgl_cnt_q  <= tgl_cnt_d;
      prev_q     <= prev_d;
    end
  end

  assign pkt_done = pkt_done_q;
  assign pkt_len  = pkt_len_q;
  assign pkt_dst  = pkt_dst_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign tgl_cnt  = tgl_cnt_q;

endmodule

// File: tb/tb_flit_rx.sv
// Directed bench for flit_rx: two receivers (MAXLEN 64 and 4) share one flit bus and
// are checked every cycle against a packet-level model plus hand-computed literals.
module tb_flit_rx;

  localparam logic [1:0] T_NONE = 2'b00;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;
  localparam logic [1:0] T_DATA = 2'b11;
  localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam longint SAT        = 64'h0000_0000_FFFF_FFFF;

  logic clk, rst, clr;
  int   nchecks, nerrors;

  flit_rx_if #(.DATAW_P1(66), .VCHW_P1(1)) bus ();

  logic        done0, done1, err0, err1;
  logic [15:0] len0, len1;
  logic [31:0] dst0, dst1, pcnt0, pcnt1, tcnt0, tcnt1;
  logic [2:0]  code0, code1;

  flit_rx #(.DATAW_P1(66), .VCHW_P1(1), .MAXLEN(64)) dut (
    .clk(clk), .rst(rst), .in_if(bus), .clr(clr),
    .pkt_done(done0), .pkt_len(len0), .pkt_dst(dst0), .err(err0),
    .err_code(code0), .pkt_cnt(pcnt0), .tgl_cnt(tcnt0));

  flit_rx #(.DATAW_P1(66), .VCHW_P1(1), .MAXLEN(4)) dut4 (
    .clk(clk), .rst(rst), .in_if(bus), .clr(clr),
    .pkt_done(done1), .pkt_len(len1), .pkt_dst(dst1), .err(err1),
    .err_code(code1), .pkt_cnt(pcnt1), .tgl_cnt(tcnt1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet-level model: per receiver, is a packet open, how many flits so far.
  bit          mdl_on;
  bit          in_pkt [2];
  int          m_len  [2];
  logic        m_vch  [2];
  logic [31:0] m_dst  [2];
  longint      m_cnt  [2];
  longint      m_tgl  [2];
  bit          e_done [2];
  bit          e_err  [2];
  logic [2:0]  e_code [2];
  logic [15:0] e_plen [2];
  logic [31:0] e_pdst [2];
  logic [63:0] m_prev;

  initial mdl_on = 1'b0;

  always @(posedge clk) begin
    logic [1:0]  t;
    logic [63:0] p;
    int          lim;
    t = bus.idata[65:64];
    p = bus.idata[63:0];
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? 64 : 4;
      e_done[k] = 1'b0;
      e_err[k]  = 1'b0;
      if (rst) begin
        in_pkt[k] = 1'b0; m_len[k] = 0; m_vch[k] = 1'b0; m_dst[k] = '0;
        m_cnt[k] = 0; m_tgl[k] = 0; e_code[k] = 3'd0; e_plen[k] = '0; e_pdst[k] = '0;
      end else begin
        if (bus.ivalid) begin
          if (t == T_NONE) begin
            e_err[k] = 1'b1; e_code[k] = 3'd3;
          end else if (t == T_HEAD) begin
            if (in_pkt[k]) begin e_err[k] = 1'b1; e_code[k] = 3'd2; end
            in_pkt[k] = 1'b1; m_len[k] = 1; m_vch[k] = bus.ivch; m_dst[k] = p[31:0];
          end else if (!in_pkt[k]) begin
            e_err[k] = 1'b1; e_code[k] = 3'd1;
          end else if (bus.ivch != m_vch[k]) begin
            e_err[k] = 1'b1; e_code[k] = 3'd4; in_pkt[k] = 1'b0;
          end else if (t == T_TAIL) begin
            in_pkt[k] = 1'b0; e_done[k] = 1'b1;
            e_plen[k] = 16'(m_len[k] + 1); e_pdst[k] = m_dst[k];
            m_cnt[k] = (m_cnt[k] + 1 > SAT) ? SAT : m_cnt[k] + 1;
          end else if (m_len[k] + 1 + 1 > lim) begin
            // this data flit would leave no room for a tail
            e_err[k] = 1'b1; e_code[k] = 3'd5; in_pkt[k] = 1'b0;
          end else begin
            m_len[k] = m_len[k] + 1;
          end
          m_tgl[k] = m_tgl[k] + longint'($countones(p ^ m_prev));
          if (m_tgl[k] > SAT) m_tgl[k] = SAT;
        end
        if (clr) begin m_cnt[k] = 0; m_tgl[k] = 0; end
      end
    end
    if (rst) m_prev = '0;
    else if (bus.ivalid) m_prev = p;
    mdl_on = 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_on) begin
      chk("done0", 64'(done0), 64'(e_done[0]));  chk("done1", 64'(done1), 64'(e_done[1]));
      chk("err0",  64'(err0),  64'(e_err[0]));   chk("err1",  64'(err1),  64'(e_err[1]));
      chk("code0", 64'(code0), 64'(e_code[0]));  chk("code1", 64'(code1), 64'(e_code[1]));
      chk("len0",  64'(len0),  64'(e_plen[0]));  chk("len1",  64'(len1),  64'(e_plen[1]));
      chk("dst0",  64'(dst0),  64'(e_pdst[0]));  chk("dst1",  64'(dst1),  64'(e_pdst[1]));
      chk("pcnt0", 64'(pcnt0), 64'(m_cnt[0]));   chk("pcnt1", 64'(pcnt1), 64'(m_cnt[1]));
      chk("tcnt0", 64'(tcnt0), 64'(m_tgl[0]));   chk("tcnt1", 64'(tcnt1), 64'(m_tgl[1]));
    end
  end

  task automatic send(input logic [1:0] t, input logic [63:0] p, input logic v);
    @(negedge clk);
    bus.idata  = {t, p};
    bus.ivalid = 1'b1;
    bus.ivch   = v;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.ivalid = 1'b0;
    bus.idata  = '0;
    bus.ivch   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    nchecks = 0; nerrors = 0;
    rst = 1'b1; clr = 1'b0;
    bus.idata = '0; bus.ivalid = 1'b0; bus.ivch = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_done", 64'(done0), 64'd0);
    chk("rst_err",  64'(err0),  64'd0);
    chk("rst_code", 64'(code0), 64'd0);
    chk("rst_len",  64'(len0),  64'd0);
    chk("rst_pcnt", 64'(pcnt0), 64'd0);
    chk("rst_tcnt", 64'(tcnt0), 64'd0);
    rst = 1'b0;

    // 22-flit packet on vch 0
    send(T_HEAD, 64'h9, 1'b0);
    for (int i = 0; i < 20; i++) send(T_DATA, {$urandom, $urandom}, 1'b0);
    send(T_TAIL, 64'h1234_5678_9ABC_DEF0, 1'b0);
    idle();
    chk("long_done", 64'(done0), 64'd1);
    chk("long_len",  64'(len0),  64'd22);
    chk("long_dst",  64'(dst0),  64'h9);
    chk("long_pcnt", 64'(pcnt0), 64'd1);
    chk("long_err",  64'(err0),  64'd0);
    idle();
    chk("long_pulse", 64'(done0), 64'd0);

    // orphan data
    send(T_DATA, 64'hA5, 1'b0);
    idle();
    chk("orphan_err",  64'(err0),  64'd1);
    chk("orphan_code", 64'(code0), 64'd1);
    chk("orphan_pcnt", 64'(pcnt0), 64'd1);

    // truncated packet restarted by a new head
    send(T_HEAD, 64'h1, 1'b0);
    for (int i = 0; i < 3; i++) send(T_DATA, 64'(i + 7), 1'b0);
    send(T_HEAD, 64'h4, 1'b0);
    send(T_DATA, 64'hFF00, 1'b0);
    chk("trunc_code", 64'(code0), 64'd2);
    send(T_TAIL, 64'h0, 1'b0);
    idle();
    chk("trunc_len", 64'(len0), 64'd3);
    chk("trunc_dst", 64'(dst0), 64'h4);

    // vch mismatch, then a now-orphaned tail
    send(T_HEAD, 64'h22, 1'b0);
    send(T_DATA, 64'h33, 1'b1);
    idle();
    chk("vch_code", 64'(code0), 64'd4);
    send(T_TAIL, 64'h44, 1'b0);
    idle();
    chk("vch_tail_code", 64'(code0), 64'd1);

    // NONE flit mid-body leaves the length alone
    send(T_HEAD, 64'h55, 1'b1);
    send(T_DATA, 64'h66, 1'b1);
    send(T_NONE, 64'h77, 1'b1);
    send(T_TAIL, 64'h88, 1'b1);
    chk("none_code", 64'(code0), 64'd3);
    idle();
    chk("none_len", 64'(len0), 64'd3);

    // MAXLEN=4 receiver overflows on the third data flit
    send(T_HEAD, 64'hC, 1'b0);
    for (int i = 0; i < 3; i++) send(T_DATA, 64'(i), 1'b0);
    idle();
    chk("max_err",   64'(err1),  64'd1);
    chk("max_code",  64'(code1), 64'd5);
    chk("max_err64", 64'(err0),  64'd0);
    send(T_TAIL, 64'h0, 1'b0);
    idle();
    chk("max_len64", 64'(len0), 64'd5);

    // idle gaps inside a packet
    send(T_HEAD, 64'hBEEF, 1'b0);
    repeat (3) idle();
    send(T_DATA, 64'h1, 1'b0);
    send(T_TAIL, 64'h2, 1'b0);
    idle();
    chk("gap_len", 64'(len0), 64'd3);

    // reset mid-packet discards it silently
    send(T_HEAD, 64'h11, 1'b0);
    send(T_DATA, 64'h1, 1'b0);
    send(T_DATA, 64'h2, 1'b0);
    idle();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    send(T_TAIL, 64'h3, 1'b0);
    idle();
    chk("rstmid_err",  64'(err0),  64'd1);
    chk("rstmid_code", 64'(code0), 64'd1);
    chk("rstmid_done", 64'(done0), 64'd0);

    // toggle accounting from a clean reset, then clear
    rst = 1'b1;
    idle();
    rst = 1'b0;
    send(T_HEAD, 64'h0, 1'b0);
    send(T_DATA, ONES, 1'b0);
    send(T_DATA, ONES, 1'b0);
    send(T_TAIL, 64'h0, 1'b0);
    idle();
    chk("tgl_128", 64'(tcnt0), 64'd128);
    clr = 1'b1;
    idle();
    clr = 1'b0;
    chk("tgl_clr",  64'(tcnt0), 64'd0);
    chk("pcnt_clr", 64'(pcnt0), 64'd0);

    // clear on the tail cycle loses that packet's increment
    send(T_HEAD, 64'h5, 1'b0);
    send(T_TAIL, 64'h6, 1'b0);
    clr = 1'b1;
    idle();
    clr = 1'b0;
    chk("clr_tail_done", 64'(done0), 64'd1);
    chk("clr_tail_pcnt", 64'(pcnt0), 64'd0);
    repeat (2) idle();

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/flit_rx.md
FLIT_RX -- requirements
Module: flit_rx

Interface
REQ-001 SHALL have parameter DATAW_P1, default 66, flit width (2-bit type field at MSBs + payload).
REQ-002 SHALL have parameter VCHW_P1, default 1, virtual-channel id width.
REQ-003 SHALL have parameter MAXLEN, default 64, maximum flits per packet (head+body+tail).
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port idata  in  DATAW_P1  incoming flit (output side of the 2:1 flit mux).
REQ-007 SHALL have port ivalid  in  1  flit valid, one flit per cycle, no backpressure.
REQ-008 SHALL have port ivch  in  VCHW_P1  virtual channel of incoming flit.
REQ-009 SHALL have port clr  in  1  synchronous clear of all statistics counters.
REQ-010 SHALL have port pkt_done  out  1  one-cycle pulse on accepted tail.
REQ-011 SHALL have port pkt_len  out  16  flit count of the last completed packet, including head and tail.
REQ-012 SHALL have port pkt_dst  out  32  payload bits [31:0] of the last completed packet's head.
REQ-013 SHALL have port err  out  1  one-cycle protocol-error pulse.
REQ-014 SHALL have port err_code  out  3  cause of the last err; held until the next error.
REQ-015 SHALL have port pkt_cnt  out  32  completed packets, saturating.
REQ-016 SHALL have port tgl_cnt  out  32  accumulated payload bit toggles between consecutive valid flits, saturating.

Function
REQ-017 SHALL decode type = idata[DATAW_P1-1 -:2] as NONE=00, HEAD=01, TAIL=10, DATA=11.
REQ-018 SHALL implement FSM IDLE/BODY; reset state IDLE.
REQ-019 IDLE + valid HEAD -> BODY; capture ivch, payload[31:0], len=1.
REQ-020 BODY + valid DATA on captured vch -> stay in BODY; len+1.
REQ-021 BODY + valid TAIL on captured vch -> IDLE; pkt_done=1, pkt_len=len+1, pkt_dst=captured value, all registered (1-cycle latency after the tail cycle).
REQ-022 IDLE + valid DATA or TAIL -> err, code 1 (orphan); state unchanged; flit dropped.
REQ-023 BODY + valid HEAD -> err, code 2 (truncated); old packet discarded; new packet starts with len=1; no pkt_done.
REQ-024 Valid NONE flit in any state -> err, code 3; state and len unchanged.
REQ-025 BODY + valid DATA/TAIL with ivch differing from captured vch -> err, code 4; return to IDLE; no pkt_done.
REQ-026 len reaching MAXLEN without a tail (next body flit would exceed it) -> err, code 5; return to IDLE.
REQ-027 ivalid=0 -> no state change; the packet may idle mid-body indefinitely.
REQ-028 tgl_cnt SHALL add popcount(payload XOR previous valid payload) on each valid flit; the previous payload register resets to 0 and updates only on valid.
REQ-029 pkt_cnt and tgl_cnt SHALL saturate at 32'hFFFFFFFF.
REQ-030 clr SHALL zero pkt_cnt and tgl_cnt next cycle; a same-cycle increment is lost; clr has no effect on FSM or packet capture.
REQ-031 At most one err per cycle; priority follows code order 3 > 2 > 4 > 5 > 1 (only one condition can apply per state in practice).

Reset
REQ-032 rst SHALL force IDLE, len=0, pkt_done=0, err=0, err_code=0, pkt_len=0, pkt_dst=0, pkt_cnt=0, tgl_cnt=0, previous payload=0.
REQ-033 rst mid-packet SHALL discard the packet silently, with no pulse and no error.

Structure
REQ-034 Type encodings, error codes and TYPE width SHALL live in the shared define/package file used by the mux and router blocks.
REQ-035 Popcount SHALL be a separate sub-module, popcount, parameterized by width.

Verification
REQ-036 HEAD(dst=0x09), 20 DATA, TAIL, all on vch 0 -> pkt_done one cycle after the tail cycle, pkt_len=22, pkt_dst=0x09, pkt_cnt=1, no err.
REQ-037 DATA with no preceding head -> err=1, err_code=1, FSM stays IDLE, pkt_cnt unchanged.
REQ-038 HEAD, 3 DATA, HEAD(dst=0x04), 1 DATA, TAIL -> one err code 2, then pkt_done with pkt_len=3, pkt_dst=0x04.
REQ-039 Payloads 0 -> all-ones -> all-ones -> 0 (64-bit) -> tgl_cnt=128; assert clr -> 0 next cycle.
REQ-040 MAXLEN=4, HEAD + 3 DATA -> err code 5 on the 3rd DATA, FSM back to IDLE.
REQ-041 rst asserted after HEAD + 2 DATA, then TAIL -> err code 1 on the TAIL, no pkt_done.
